// File: rtl/sparse_tok_pkg.sv
// Sparse token encoding shared by the fiber scanners and intersectors.
// Bit 16 marks a control token; DONE and STOP_n (n in 0..255) are the only legal control tokens.
package sparse_tok_pkg;

  localparam int DW = 17;
  localparam logic [16:0] TOK_DONE      = 17'h10100;
  localparam logic [16:0] TOK_STOP_BASE = 17'h10000;

  typedef logic [16:0] tok_t;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } isect_state_t;

  function automatic logic is_ctrl(input tok_t t);
    return t[16];
  endfunction

  function automatic logic is_done(input tok_t t);
    return t == TOK_DONE;
  endfunction

  function automatic logic is_stop(input tok_t t);
    return t[16] && (t[15:8] == 8'h00);
  endfunction

  // Illegal control tokens read as level 0 so they behave like STOP_0.
  function automatic logic [7:0] stop_lvl(input tok_t t);
    return is_stop(t) ? t[7:0] : 8'h00;
  endfunction

endpackage

// File: rtl/reg_fifo.sv
// Register-based FIFO; data_out is valid whenever empty is low, no read latency.
// Latency: push to non-empty 1 cycle; push is ignored when full, pop ignored when empty.
module reg_fifo #(
  parameter int DW    = 17,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] data_in,
  output logic          full,
  input  logic          pop,
  output logic [DW-1:0] data_out,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/coord_intersect_2.sv
// Two-way sparse intersector: 2-pointer merge of (coord,pos) fibers, emits common coords with both positions.
// Latency 1 cycle through output FIFOs; a step needs both operands present and all three FIFOs non-full.
module coord_intersect_2
  import sparse_tok_pkg::*;
#(
  parameter int DW          = 17,
  parameter int OFIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          flush,
  input  logic          tile_en,
  input  logic [DW-1:0] coord_in_0,
  input  logic          coord_in_0_valid,
  output logic          coord_in_0_ready,
  input  logic [DW-1:0] pos_in_0,
  input  logic          pos_in_0_valid,
  output logic          pos_in_0_ready,
  input  logic [DW-1:0] coord_in_1,
  input  logic          coord_in_1_valid,
  output logic          coord_in_1_ready,
  input  logic [DW-1:0] pos_in_1,
  input  logic          pos_in_1_valid,
  output logic          pos_in_1_ready,
  output logic [DW-1:0] coord_out,
  output logic          coord_out_valid,
  input  logic          coord_out_ready,
  output logic [DW-1:0] pos_out_0,
  output logic          pos_out_0_valid,
  input  logic          pos_out_0_ready,
  output logic [DW-1:0] pos_out_1,
  output logic          pos_out_1_valid,
  input  logic          pos_out_1_ready,
  output logic          align_err
);

  isect_state_t state;

  tok_t a_crd, b_crd, a_pos, b_pos;
  logic a_pres, b_pres, active, room, can_step;
  logic a_data, b_data, a_stop, b_stop, a_bad, b_bad;
  logic [7:0] a_lvl, b_lvl, max_lvl;
  logic pop_a, pop_b, push, set_err, to_done;
  tok_t wd_c, wd_0, wd_1;
  logic full_c, full_0, full_1, empty_c, empty_0, empty_1;

  assign a_crd = coord_in_0;
  assign b_crd = coord_in_1;
  assign a_pos = pos_in_0;
  assign b_pos = pos_in_1;

  always_comb begin
    a_pres   = coord_in_0_valid && pos_in_0_valid;
    b_pres   = coord_in_1_valid && pos_in_1_valid;
    active   = clk_en && tile_en && rst_n && !flush;
    room     = !full_c && !full_0 && !full_1;
    can_step = active && (state != ST_DONE) && a_pres && b_pres && room;

    a_data  = !is_ctrl(a_crd);
    b_data  = !is_ctrl(b_crd);
    a_stop  = is_ctrl(a_crd) && !is_done(a_crd);
    b_stop  = is_ctrl(b_crd) && !is_done(b_crd);
    a_bad   = a_stop && !is_stop(a_crd);
    b_bad   = b_stop && !is_stop(b_crd);
    a_lvl   = stop_lvl(a_crd);
    b_lvl   = stop_lvl(b_crd);
    max_lvl = (a_lvl > b_lvl) ? a_lvl : b_lvl;

    pop_a   = 1'b0;
    pop_b   = 1'b0;
    push    = 1'b0;
    set_err = 1'b0;
    to_done = 1'b0;
    wd_c    = a_crd;
    wd_0    = a_pos;
    wd_1    = b_pos;

    if (can_step) begin
      set_err = a_bad || b_bad;
      if (a_data && b_data) begin
        if (a_crd[15:0] == b_crd[15:0]) begin
          push  = 1'b1;
          pop_a = 1'b1;
          pop_b = 1'b1;
        end else if (a_crd[15:0] < b_crd[15:0]) begin
          pop_a = 1'b1;
        end else begin
          pop_b = 1'b1;
        end
      end else if (a_data) begin
        pop_a = 1'b1;
      end else if (b_data) begin
        pop_b = 1'b1;
      end else if (a_stop && b_stop) begin
        push  = 1'b1;
        pop_a = 1'b1;
        pop_b = 1'b1;
        wd_c  = TOK_STOP_BASE | {9'd0, max_lvl};
        wd_0  = wd_c;
        wd_1  = wd_c;
        if (a_lvl != b_lvl) set_err = 1'b1;
      end else if (a_stop) begin
        pop_a   = 1'b1;
        set_err = 1'b1;
      end else if (b_stop) begin
        pop_b   = 1'b1;
        set_err = 1'b1;
      end else begin
        push    = 1'b1;
        pop_a   = 1'b1;
        pop_b   = 1'b1;
        to_done = 1'b1;
        wd_c    = TOK_DONE;
        wd_0    = TOK_DONE;
        wd_1    = TOK_DONE;
      end
    end
  end

  assign coord_in_0_ready = pop_a;
  assign pos_in_0_ready   = pop_a;
  assign coord_in_1_ready = pop_b;
  assign pos_in_1_ready   = pop_b;

  assign coord_out_valid = !empty_c && active;
  assign pos_out_0_valid = !empty_0 && active;
  assign pos_out_1_valid = !empty_1 && active;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state     <= ST_START;
      align_err <= 1'b0;
    end else if (clk_en && tile_en) begin
      if (set_err) align_err <= 1'b1;
      case (state)
        ST_START: begin
          if (to_done)              state <= ST_DONE;
          else if (a_pres && b_pres) state <= ST_RUN;
        end
        ST_RUN:  if (to_done) state <= ST_DONE;
        // Hold inputs off until the last DONE has left every output.
        ST_DONE: if (empty_c && empty_0 && empty_1) state <= ST_START;
        default: state <= ST_START;
      endcase
    end
  end

  reg_fifo #(.DW(DW), .DEPTH(OFIFO_DEPTH)) u_fifo_crd (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push(push), .data_in(wd_c), .full(full_c),
    .pop(coord_out_valid && coord_out_ready), .data_out(coord_out), .empty(empty_c)
  );

  reg_fifo #(.DW(DW), .DEPTH(OFIFO_DEPTH)) u_fifo_pos0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push(push), .data_in(wd_0), .full(full_0),
    .pop(pos_out_0_valid && pos_out_0_ready), .data_out(pos_out_0), .empty(empty_0)
  );

  reg_fifo #(.DW(DW), .DEPTH(OFIFO_DEPTH)) u_fifo_pos1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push(push), .data_in(wd_1), .full(full_1),
    .pop(pos_out_1_valid && pos_out_1_ready), .data_out(pos_out_1), .empty(empty_1)
  );

endmodule
